// File: rtl/sync_buffer_fifo.sv
// sync_buffer_fifo: parametrised single-clock FIFO with occupancy count,
// status flags and sticky overflow/underflow error flags.
//
// Access semantics: a write is taken on a rising edge when wen is high and
// the FIFO was not full at the start of that cycle; a read is taken when ren
// is high and the FIFO was not empty at the start of that cycle. A refused
// request is dropped (never retried) and sets the matching sticky error flag.
// Accepted reads present their word on dout with a one-cycle dvalid pulse
// after the same edge; dout then holds until the next accepted read.
module sync_buffer_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int AFULL_LVL  = 48,
  parameter int AEMPTY_LVL = 8
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  ren,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decisions use only registered state, so a full FIFO refuses the
  // write even when a read frees a slot in the same cycle (and vice versa).
  always_comb begin
    wr_ok = wen && !full;
    rd_ok = ren && !empty;
  end

  // Status flags decoded from the registered count only.
  always_comb begin
    full         = (cnt == DEPTH_C);
    empty        = (cnt == '0);
    almost_full  = (cnt >= AFULL_C);
    almost_empty = (cnt <= AEMPTY_C);
    count        = cnt;
  end

  // Storage array: no reset, contents are undefined until written.
  always_ff @(posedge wclk) begin
    if (!rst && wr_ok) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= din;
    end
  end

  // Pointers and occupancy; the wrap bit makes wptr - rptr equal cnt.
  always_ff @(posedge wclk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ONE_C;
      if (rd_ok) rptr <= rptr + ONE_C;
      if (wr_ok && !rd_ok)      cnt <= cnt + ONE_C;
      else if (rd_ok && !wr_ok) cnt <= cnt - ONE_C;
    end
  end

  // Registered read port; reset discards any read taken in the same cycle.
  always_ff @(posedge wclk) begin
    if (rst) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      dvalid <= rd_ok;
      if (rd_ok) dout <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

  // Sticky error flags; a new error wins over a clear in the same cycle.
  always_ff @(posedge wclk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && full)  overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (ren && empty)  underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_buffer_fifo.sv
// tb_sync_buffer_fifo: directed and randomized stimulus against a queue-based
// reference model of the FIFO behaviour.
module tb_sync_buffer_fifo;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int AFL   = 48;
  localparam int AEL   = 8;

  // Clock and DUT signals
  logic          wclk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  always #5 wclk = ~wclk;

  sync_buffer_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .wclk(wclk), .rst(rst), .din(din), .wen(wen), .ren(ren),
    .clr_err(clr_err), .dout(dout), .dvalid(dvalid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_dv = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  logic [DW-1:0] seq = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    n = exp_q.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("almost_full", 64'(almost_full), 64'(n >= AFL));
    chk("almost_empty", 64'(almost_empty), 64'(n <= AEL));
    chk("dvalid", 64'(dvalid), 64'(m_dv));
    chk("dout", 64'(dout), 64'(m_dout));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input bit r_st, input bit w, input bit rd, input bit c,
                      input logic [DW-1:0] d);
    bit was_full, was_empty;
    rst = r_st; wen = w; ren = rd; clr_err = c; din = d;
    @(posedge wclk);
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (r_st) begin
      exp_q.delete();
      m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (rd && !was_empty) begin
        m_dout = exp_q.pop_front();
        m_dv = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (w && !was_full) exp_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      if (rd && was_empty) m_udf = 1'b1;
      else if (c)          m_udf = 1'b0;
    end
    #1;
    compare_all();
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic read_word();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic idle_clr();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  // Directed and randomized sequence
  initial begin
    bit w, r;

    // Reset with both requests active
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);

    // Fill to full, then overflow and clear
    for (int i = 1; i <= DEPTH; i++) write_word(DW'(i));
    chk("fill_full", 64'(full), 64'd1);
    write_word(32'hFF);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd64);
    idle_clr();
    chk("ovf_clr", 64'(overflow), 64'd0);
    // set wins over clear in the same cycle
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hEE);
    chk("ovf_set_prio", 64'(overflow), 64'd1);
    idle_clr();

    // Drain in order, then underflow
    for (int i = 1; i <= DEPTH; i++) begin
      read_word();
      chk("drain_data", 64'(dout), 64'(i));
    end
    read_word();
    chk("udf_dout_hold", 64'(dout), 64'h40);
    chk("udf_set", 64'(underflow), 64'd1);
    idle_clr();

    // Simultaneous access when empty: write only
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    chk("sim_empty_count", 64'(count), 64'd1);
    chk("sim_empty_udf", 64'(underflow), 64'd1);
    idle_clr();

    // Simultaneous access when full: read only
    seq = 32'h1000;
    while (exp_q.size() < DEPTH) begin
      seq++;
      write_word(seq);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
    chk("sim_full_count", 64'(count), 64'd63);
    chk("sim_full_oldest", 64'(dout), 64'h100);
    idle_clr();

    // Simultaneous access mid-range: both taken
    while (exp_q.size() > 10) read_word();
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    chk("sim_mid_count", 64'(count), 64'd10);

    // Streaming around a low occupancy across several pointer wraps
    while (exp_q.size() > 5) read_word();
    seq = 32'h5000;
    for (int i = 0; i < 256; i++) begin
      w = (exp_q.size() < 8) ? ($urandom_range(0, 7) != 0) : 1'b0;
      r = (exp_q.size() > 2) ? ($urandom_range(0, 7) != 0) : 1'b0;
      if (w) seq++;
      step(1'b0, w, r, 1'b0, seq);
    end

    // Reset in the middle of an accepted read
    idle_clr();
    while (exp_q.size() < 30) begin
      seq++;
      write_word(seq);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("rst_mid_dvalid", 64'(dvalid), 64'd0);
    write_word(32'hA5);
    read_word();
    chk("rst_mid_a5", 64'(dout), 64'hA5);

    // Fully random traffic including clears and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
